fetch_seq: RTL

FETCH_SEQ -- requirements
Module: fetch_seq

---
 rtl/fetch_seq.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/fetch_seq.sv
// fetch_seq: next-PC sequencer for the fetch stage.
// It picks the next PC from the redirect sources by priority and holds a
// redirect that arrives during a stall until the stall clears.
// Optional macro FETCH_SEQ_INT_EN adds interrupt entry and eret return with
// epc/exl state. When the macro is undefined, int_req and eret are ignored
// and epc/exl are tied to zero.
module fetch_seq #(
   parameter logic [31:0] RESET_PC   = 32'h00003000,
   parameter logic [31:0] HANDLER_PC = 32'h00004180
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc4,
   input  logic        stall,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        jmp,
   input  logic [31:0] jmp_target,
   input  logic        int_req,
   input  logic        eret,
   output logic [31:0] npc,
   output logic        pc_en,
   output logic        flush,
   output logic [31:0] epc,
   output logic        exl
);

   typedef enum logic {RUN, PEND} state_t;

   state_t      state, state_nx;
   logic [31:0] pend_pc, pend_pc_nx;
   logic [31:0] win_pc;
   logic        win_redirect;
   logic        win_int, win_eret;
   logic        take_int, take_eret;

`ifdef FETCH_SEQ_INT_EN
   logic [31:0] epc_q;
   logic        exl_q;
   logic        pend_int, pend_int_nx;
   logic        pend_eret, pend_eret_nx;

   assign epc = epc_q;
   assign exl = exl_q;
`else
   logic unused_inputs;

   assign unused_inputs = ^{int_req, eret, take_int, take_eret};
   assign epc = 32'h0;
   assign exl = 1'b0;
`endif

   // Choose the highest-priority redirect target for this cycle
   always_comb begin
      win_pc       = pc4;
      win_redirect = 1'b0;
      win_int      = 1'b0;
      win_eret     = 1'b0;
`ifdef FETCH_SEQ_INT_EN
      if (int_req && !exl_q) begin
         win_pc       = HANDLER_PC;
         win_redirect = 1'b1;
         win_int      = 1'b1;
      end else if (eret) begin
         win_pc       = epc_q;
         win_redirect = 1'b1;
         win_eret     = 1'b1;
      end else
`endif
      if (jmp) begin
         win_pc       = jmp_target;
         win_redirect = 1'b1;
      end else if (br_taken) begin
         win_pc       = br_target;
         win_redirect = 1'b1;
      end
   end

   // Next-state and output logic: issue now, park under stall, or release
   always_comb begin
      state_nx   = state;
      pend_pc_nx = pend_pc;
      npc        = pc4;
      pc_en      = 1'b0;
      flush      = 1'b0;
      take_int   = 1'b0;
      take_eret  = 1'b0;
`ifdef FETCH_SEQ_INT_EN
      pend_int_nx  = pend_int;
      pend_eret_nx = pend_eret;
`endif
      if (!rst) begin
         npc   = RESET_PC;
         pc_en = 1'b1;
         flush = 1'b1;
      end else begin
         case (state)
            RUN: begin
               if (!stall) begin
                  npc       = win_pc;
                  pc_en     = 1'b1;
                  flush     = win_redirect;
                  take_int  = win_int;
                  take_eret = win_eret;
               end else if (win_redirect) begin
                  pend_pc_nx = win_pc;
                  state_nx   = PEND;
`ifdef FETCH_SEQ_INT_EN
                  pend_int_nx  = win_int;
                  pend_eret_nx = win_eret;
`endif
               end
            end
            PEND: begin
               if (!stall) begin
                  npc      = pend_pc;
                  pc_en    = 1'b1;
                  flush    = 1'b1;
                  state_nx = RUN;
`ifdef FETCH_SEQ_INT_EN
                  take_int  = pend_int;
                  take_eret = pend_eret;
               end else if (int_req && !exl_q) begin
                  pend_pc_nx   = HANDLER_PC;
                  pend_int_nx  = 1'b1;
                  pend_eret_nx = 1'b0;
`endif
               end
            end
            default: state_nx = RUN;
         endcase
      end
   end

   // State and pending-target registers; reset drops any parked redirect
   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= RUN;
         pend_pc <= RESET_PC;
      end else begin
         state   <= state_nx;
         pend_pc <= pend_pc_nx;
      end
   end

`ifdef FETCH_SEQ_INT_EN
   // Exception state: save the interrupted PC on entry, leave on eret
   always_ff @(posedge clk) begin
      if (!rst) begin
         epc_q     <= 32'h0;
         exl_q     <= 1'b0;
         pend_int  <= 1'b0;
         pend_eret <= 1'b0;
      end else begin
         pend_int  <= pend_int_nx;
         pend_eret <= pend_eret_nx;
         if (take_int) begin
            epc_q <= pc4 - 32'd4;
            exl_q <= 1'b1;
         end else if (take_eret) begin
            exl_q <= 1'b0;
         end
      end
   end
`endif

endmodule
